// File: rtl/ahb_master_req_gen.sv
// ahb_master_req_gen: per-master decoder that raises one slave-arbiter request per transaction,
// stalls the master until granted, counts burst beats and answers unmapped addresses with ERROR.
module ahb_master_req_gen #(
    parameter int SLAVE_NUM  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_BITS   = 4
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [ADDR_WIDTH-1:0] m_haddr,
    input  logic [1:0]            m_htrans,
    input  logic [2:0]            m_hburst,
    output logic                  m_hready,
    output logic                  m_hresp_err,
    input  logic [SLAVE_NUM-1:0]  hgrant,
    output logic [SLAVE_NUM-1:0]  hreq,
    output logic [2:0]            hburst_out,
    output logic [SEL_BITS-1:0]   sel_idx
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_ERR1, S_ERR2} state_t;
    state_t state, state_n;
    logic [SEL_BITS-1:0] idx, sel_n;
    logic [2:0] burst_n;
    logic [3:0] cnt, cnt_n, limit;
    logic [SLAVE_NUM-1:0] hreq_n;
    logic valid, grant, beat, incr, incr_ns, incr_end, unused_addr;
    assign idx = m_haddr[ADDR_WIDTH-1 -: SEL_BITS];
    assign unused_addr = ^m_haddr[ADDR_WIDTH-SEL_BITS-1:0];
    assign valid = {1'b0, idx} < (SEL_BITS+1)'(SLAVE_NUM);
    // hreq is one-hot at sel_idx whenever a grant matters, so it doubles as the grant mask
    assign grant = |(hgrant & hreq);
    assign beat = grant && m_htrans[1];
    assign incr = hburst_out == 3'd1;
    assign incr_ns = incr && m_htrans == 2'd2 && cnt != 4'd0;
    assign incr_end = incr_ns || (incr && grant && m_htrans == 2'd0);
    assign limit = hburst_out[2:1] == 2'd0 ? 4'd0 :
                   hburst_out[2:1] == 2'd1 ? 4'd3 :
                   hburst_out[2:1] == 2'd2 ? 4'd7 : 4'd15;
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= S_IDLE;
            hreq       <= '0;
            sel_idx    <= '0;
            hburst_out <= 3'd0;
            cnt        <= 4'd0;
        end else begin
            state      <= state_n;
            hreq       <= hreq_n;
            sel_idx    <= sel_n;
            hburst_out <= burst_n;
            cnt        <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        sel_n   = sel_idx;
        burst_n = hburst_out;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (m_htrans == 2'd2) begin
                state_n = valid ? S_REQ : S_ERR1;
                sel_n   = valid ? idx : sel_idx;
                burst_n = valid ? m_hburst : hburst_out;
                cnt_n   = 4'd0;
            end
            S_REQ:  state_n = grant ? S_XFER : S_REQ;
            S_XFER: if (incr_end || (!incr && beat && cnt == limit)) begin
                state_n = S_IDLE;
                cnt_n   = 4'd0;
            end else if (beat) begin
                // INCR saturates so a long undefined-length burst never wraps to zero
                cnt_n = cnt + {3'd0, cnt != 4'hf};
            end
            S_ERR1: state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase
        hreq_n = (state_n == S_REQ || state_n == S_XFER) ? SLAVE_NUM'(1) << sel_n : '0;
    end
    always_comb begin
        m_hready    = (state == S_REQ || state == S_ERR1) ? 1'b0 :
                      state == S_XFER ? grant && !incr_ns : 1'b1;
        m_hresp_err = state == S_ERR1 || state == S_ERR2;
    end
endmodule

// File: tb/tb_ahb_master_req_gen.sv
// tb_ahb_master_req_gen: directed per-cycle vector table for ahb_master_req_gen plus a
// hand-written asynchronous reset sequence in the middle of an INCR16 burst.
module tb_ahb_master_req_gen;
    logic        clk = 1'b0;
    logic        hreset;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hburst;
    logic        m_hready, m_hresp_err;
    logic [7:0]  hgrant, hreq;
    logic [2:0]  hburst_out;
    logic [3:0]  sel_idx;
    logic [16:0] act;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tr;
        logic [2:0]  bu;
        logic [7:0]  g;
        logic [16:0] exp;
    } vec_t;
    vec_t v[$];

    localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;

    ahb_master_req_gen dut (
        .hclk(clk), .hreset(hreset), .m_haddr(m_haddr), .m_htrans(m_htrans),
        .m_hburst(m_hburst), .m_hready(m_hready), .m_hresp_err(m_hresp_err),
        .hgrant(hgrant), .hreq(hreq), .hburst_out(hburst_out), .sel_idx(sel_idx)
    );

    always #5 clk = ~clk;
    assign act = {m_hready, m_hresp_err, hreq, hburst_out, sel_idx};

    // expected: ready, err, hreq, hburst_out, sel_idx during the cycle the inputs are applied
    function automatic void add(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                                input logic [7:0] g, input logic r, input logic e,
                                input logic [7:0] q, input logic [2:0] bo, input logic [3:0] s);
        v.push_back('{a, t, b, g, {r, e, q, bo, s}});
    endfunction

    task automatic chk(input string nm, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got rdy=%b err=%b hreq=%h bo=%0d sel=%0d want rdy=%b err=%b hreq=%h bo=%0d sel=%0d",
                     nm, act[16], act[15], act[14:7], act[6:4], act[3:0],
                     exp[16], exp[15], exp[14:7], exp[6:4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b, input logic [7:0] g);
        m_haddr = a; m_htrans = t; m_hburst = b; hgrant = g;
    endtask

    initial begin
        // SINGLE to slave 2
        add(32'h2000_0000, N, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        add(32'h2000_0000, N, 0, 8'h04, 0, 0, 8'h04, 0, 2);
        add(32'h2000_0000, N, 0, 8'h04, 1, 0, 8'h04, 0, 2);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 0, 2);
        // INCR4 to slave 5, grant toggling 1,0,1,1,1 in XFER
        add(32'h5000_0000, N, 3, 8'h00, 1, 0, 8'h00, 0, 2);
        add(32'h5000_0000, N, 3, 8'h20, 0, 0, 8'h20, 3, 5);
        add(32'h5000_0000, N, 3, 8'h20, 1, 0, 8'h20, 3, 5);
        add(32'h5000_0004, S, 3, 8'h00, 0, 0, 8'h20, 3, 5);
        add(32'h5000_0004, S, 3, 8'h20, 1, 0, 8'h20, 3, 5);
        add(32'h5000_0008, S, 3, 8'h20, 1, 0, 8'h20, 3, 5);
        add(32'h5000_000C, S, 3, 8'h20, 1, 0, 8'h20, 3, 5);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 3, 5);
        // INCR to slave 1, 6 beats, IDLE ends it, then SINGLE to slave 3 after one bubble
        add(32'h1000_0000, N, 1, 8'h00, 1, 0, 8'h00, 3, 5);
        add(32'h1000_0000, N, 1, 8'h02, 0, 0, 8'h02, 1, 1);
        add(32'h1000_0000, N, 1, 8'h02, 1, 0, 8'h02, 1, 1);
        for (int k = 0; k < 5; k++) add(32'h1000_0004, S, 1, 8'h02, 1, 0, 8'h02, 1, 1);
        add(32'h0000_0000, I, 1, 8'h02, 1, 0, 8'h02, 1, 1);
        add(32'h3000_0000, N, 0, 8'h00, 1, 0, 8'h00, 1, 1);
        add(32'h3000_0000, N, 0, 8'h08, 0, 0, 8'h08, 0, 3);
        add(32'h3000_0000, N, 0, 8'h08, 1, 0, 8'h08, 0, 3);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 0, 3);
        // INCR to slave 1 terminated by NONSEQ to slave 4 (not accepted, re-decoded)
        add(32'h1000_0000, N, 1, 8'h00, 1, 0, 8'h00, 0, 3);
        add(32'h1000_0000, N, 1, 8'h02, 0, 0, 8'h02, 1, 1);
        add(32'h1000_0000, N, 1, 8'h02, 1, 0, 8'h02, 1, 1);
        add(32'h1000_0004, S, 1, 8'h02, 1, 0, 8'h02, 1, 1);
        add(32'h4000_0000, N, 0, 8'h02, 0, 0, 8'h02, 1, 1);
        add(32'h4000_0000, N, 0, 8'h00, 1, 0, 8'h00, 1, 1);
        add(32'h4000_0000, N, 0, 8'h10, 0, 0, 8'h10, 0, 4);
        add(32'h4000_0000, N, 0, 8'h10, 1, 0, 8'h10, 0, 4);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 0, 4);
        // unmapped address
        add(32'hC000_0000, N, 0, 8'h00, 1, 0, 8'h00, 0, 4);
        add(32'h0000_0000, I, 0, 8'hFF, 0, 1, 8'h00, 0, 4);
        add(32'h0000_0000, I, 0, 8'hFF, 1, 1, 8'h00, 0, 4);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 0, 4);
        // WRAP8 to slave 6 with BUSY, foreign grants, and address/burst changes mid-burst
        add(32'h6000_0000, N, 4, 8'hBF, 1, 0, 8'h00, 0, 4);
        add(32'h6000_0000, N, 4, 8'hBF, 0, 0, 8'h40, 4, 6);
        add(32'h6000_0000, N, 4, 8'hFF, 0, 0, 8'h40, 4, 6);
        add(32'h6000_0000, N, 4, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h6000_0004, B, 4, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h1000_0000, S, 0, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h1000_0000, S, 0, 8'hBF, 0, 0, 8'h40, 4, 6);
        add(32'h1000_0000, S, 0, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h1000_0000, S, 0, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h1000_0000, B, 0, 8'hFF, 1, 0, 8'h40, 4, 6);
        for (int k = 0; k < 4; k++) add(32'h1000_0000, S, 0, 8'hFF, 1, 0, 8'h40, 4, 6);
        add(32'h0000_0000, I, 0, 8'h00, 1, 0, 8'h00, 4, 6);
        // INCR16 to slave 7, 7 beats accepted before the reset sequence below
        add(32'h7000_0000, N, 7, 8'h00, 1, 0, 8'h00, 4, 6);
        add(32'h7000_0000, N, 7, 8'h80, 0, 0, 8'h80, 7, 7);
        add(32'h7000_0000, N, 7, 8'h80, 1, 0, 8'h80, 7, 7);
        for (int k = 0; k < 6; k++) add(32'h7000_0004, S, 7, 8'h80, 1, 0, 8'h80, 7, 7);

        hreset = 1'b1;
        drive(32'h0, I, 0, 8'h00);
        @(negedge clk); #1;
        chk("reset", {1'b1, 1'b0, 8'h00, 3'd0, 4'd0});
        hreset = 1'b0;
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            drive(v[i].addr, v[i].tr, v[i].bu, v[i].g);
            #1;
            chk($sformatf("vec%0d", i), v[i].exp);
        end
        @(negedge clk);
        drive(32'h7000_0020, S, 7, 8'h80);
        #1;
        chk("incr16_beat8", {1'b1, 1'b0, 8'h80, 3'd7, 4'd7});
        #2 hreset = 1'b1;
        #1 chk("async_reset", {1'b1, 1'b0, 8'h00, 3'd0, 4'd0});
        @(negedge clk); #1;
        chk("reset_hold", {1'b1, 1'b0, 8'h00, 3'd0, 4'd0});
        hreset = 1'b0;
        @(negedge clk);
        drive(32'h0, I, 0, 8'h80);
        #1;
        chk("post_reset_idle", {1'b1, 1'b0, 8'h00, 3'd0, 4'd0});
        @(negedge clk);
        drive(32'h0000_0000, N, 0, 8'h01);
        #1;
        chk("post_reset_nonseq", {1'b1, 1'b0, 8'h00, 3'd0, 4'd0});
        @(negedge clk); #1;
        chk("post_reset_req", {1'b0, 1'b0, 8'h01, 3'd0, 4'd0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
